// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: opcodes, multiplier FSM states, width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The multiplier feature is selected by the EX_MUL_EN macro in the users of this package.
package ex_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 4;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SLL = 4'h5;
    localparam logic [3:0] OP_SRL = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low DW bits of the product.
// Latency: MUL_CYC+2 cycles from start (IDLE capture, MUL_CYC steps, DONE).
// Backpressure: stall is high in the capturing IDLE cycle and every BUSY cycle; low in DONE and during reset.
module ex_mul_seq
    import ex_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int MUL_CYC = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] product
);

    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);

    mul_state_t    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] acc;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;

    // Sequencer: capture operands in IDLE, accumulate shifted multiplicand per set multiplier bit in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= a_in;
                        mplier <= b_in;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall is gated by reset so it drops the moment reset asserts, even with a MUL still presented.
    assign stall   = rst_n && (((state == IDLE) && start) || (state == BUSY));
    assign done    = (state == DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, optional iterative MUL (macro EX_MUL_EN), owns the EX/MEM register.
// Latency: 1 cycle for single-cycle ops; MUL_CYC+2 cycles for MUL with bubbles loaded into EX/MEM meanwhile.
// Backpressure: ex_stall (combinational) asks upstream to hold PC, IF/ID and ID/EX while a MUL is in progress.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int MUL_CYC = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MReg_in,
    input  logic          MR_in,
    input  logic          MW_in,
    input  logic          ALU_src_in,
    input  logic          EnRW_in,
    input  logic [3:0]    opcode_in,
    input  logic [DW-1:0] rd1_in,
    input  logic [DW-1:0] rd2_in,
    input  logic [DW-1:0] sign_ext_in,
    input  logic [RW-1:0] reg_rs_in,
    input  logic [RW-1:0] reg_rt_in,
    input  logic [RW-1:0] reg_rd_in,
    input  logic          fwd_em_we,
    input  logic [RW-1:0] fwd_em_rd,
    input  logic [DW-1:0] fwd_em_data,
    input  logic          fwd_mw_we,
    input  logic [RW-1:0] fwd_mw_rd,
    input  logic [DW-1:0] fwd_mw_data,
    output logic          ex_stall,
    output logic          MReg_out,
    output logic          MR_out,
    output logic          MW_out,
    output logic          EnRW_out,
    output logic [DW-1:0] alu_result_out,
    output logic [DW-1:0] store_data_out,
    output logic [RW-1:0] reg_rd_out
);

    localparam int SHW = $clog2(DW);

    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_res;
    logic          op_nop;
    logic          mul_bubble;

    logic          n_mreg;
    logic          n_mr;
    logic          n_mw;
    logic          n_enrw;
    logic [DW-1:0] n_alu;
    logic [DW-1:0] n_store;
    logic [RW-1:0] n_rd;

    // Operand A: the younger EX/MEM result beats MEM/WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rd1_in;
        if (fwd_em_we && (fwd_em_rd == reg_rs_in) && (reg_rs_in != '0)) begin
            fwd_a = fwd_em_data;
        end else if (fwd_mw_we && (fwd_mw_rd == reg_rs_in) && (reg_rs_in != '0)) begin
            fwd_a = fwd_mw_data;
        end
    end

    // Operand B (rt) with the same priority; this value also feeds the SW store data.
    always_comb begin
        fwd_b = rd2_in;
        if (fwd_em_we && (fwd_em_rd == reg_rt_in) && (reg_rt_in != '0)) begin
            fwd_b = fwd_em_data;
        end else if (fwd_mw_we && (fwd_mw_rd == reg_rt_in) && (reg_rt_in != '0)) begin
            fwd_b = fwd_mw_data;
        end
    end

    assign op_b = ALU_src_in ? sign_ext_in : fwd_b;

`ifdef EX_MUL_EN
    logic          mul_stall;
    logic          mul_done;
    logic [DW-1:0] mul_product;

    // The multiplier latches fwd_a/fwd_b itself, so later forwarding changes cannot disturb it.
    ex_mul_seq #(
        .DW      (DW),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (opcode_in == OP_MUL),
        .a_in    (fwd_a),
        .b_in    (fwd_b),
        .stall   (mul_stall),
        .done    (mul_done),
        .product (mul_product)
    );

    assign mul_bubble = mul_stall;
    assign ex_stall   = mul_stall;
`else
    logic unused_cfg;

    // Without the multiplier, MUL_CYC only documents the intended relation to DW.
    assign unused_cfg = (MUL_CYC == DW);
    assign mul_bubble = 1'b0;
    assign ex_stall   = 1'b0;
`endif

    // ALU: arithmetic wraps modulo 2^DW; unassigned opcodes are NOPs.
    always_comb begin
        alu_res = '0;
        op_nop  = 1'b0;
        case (opcode_in)
            OP_ADD, OP_LW, OP_SW: alu_res = fwd_a + op_b;
            OP_SUB:               alu_res = fwd_a - op_b;
            OP_AND:               alu_res = fwd_a & op_b;
            OP_OR:                alu_res = fwd_a | op_b;
            OP_XOR:               alu_res = fwd_a ^ op_b;
            OP_SLL:               alu_res = fwd_a << op_b[SHW-1:0];
            OP_SRL:               alu_res = fwd_a >> op_b[SHW-1:0];
            OP_SLT:               alu_res = {{(DW-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
`ifdef EX_MUL_EN
            // Only reaches EX/MEM in DONE; every earlier MUL cycle is a bubble.
            OP_MUL:               alu_res = mul_product;
`endif
            default: begin
                alu_res = '0;
                op_nop  = 1'b1;
            end
        endcase
    end

    // Next EX/MEM contents: pass ID/EX through, or load an all-zero bubble for NOPs and MUL wait cycles.
    always_comb begin
        n_mreg  = MReg_in;
        n_mr    = MR_in;
        n_mw    = MW_in;
        n_enrw  = EnRW_in;
        n_alu   = alu_res;
        n_store = fwd_b;
        n_rd    = reg_rd_in;
        if (op_nop || mul_bubble) begin
            n_mreg  = 1'b0;
            n_mr    = 1'b0;
            n_mw    = 1'b0;
            n_enrw  = 1'b0;
            n_alu   = '0;
            n_store = '0;
            n_rd    = '0;
        end
    end

    // EX/MEM pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MReg_out       <= 1'b0;
            MR_out         <= 1'b0;
            MW_out         <= 1'b0;
            EnRW_out       <= 1'b0;
            alu_result_out <= '0;
            store_data_out <= '0;
            reg_rd_out     <= '0;
        end else begin
            MReg_out       <= n_mreg;
            MR_out         <= n_mr;
            MW_out         <= n_mw;
            EnRW_out       <= n_enrw;
            alu_result_out <= n_alu;
            store_data_out <= n_store;
            reg_rd_out     <= n_rd;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    localparam int DW = 32;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          MReg_in, MR_in, MW_in, ALU_src_in, EnRW_in;
    logic [3:0]    opcode_in;
    logic [DW-1:0] rd1_in, rd2_in, sign_ext_in;
    logic [RW-1:0] reg_rs_in, reg_rt_in, reg_rd_in;
    logic          fwd_em_we, fwd_mw_we;
    logic [RW-1:0] fwd_em_rd, fwd_mw_rd;
    logic [DW-1:0] fwd_em_data, fwd_mw_data;
    logic          ex_stall;
    logic          MReg_out, MR_out, MW_out, EnRW_out;
    logic [DW-1:0] alu_result_out, store_data_out;
    logic [RW-1:0] reg_rd_out;
    logic [3:0]    ctrl_o;

    always #5 clk = ~clk;

    assign ctrl_o = {MReg_out, MR_out, MW_out, EnRW_out};

    ex_stage #(.DW(DW), .RW(RW), .MUL_CYC(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .MReg_in(MReg_in), .MR_in(MR_in), .MW_in(MW_in), .ALU_src_in(ALU_src_in), .EnRW_in(EnRW_in),
        .opcode_in(opcode_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .sign_ext_in(sign_ext_in),
        .reg_rs_in(reg_rs_in), .reg_rt_in(reg_rt_in), .reg_rd_in(reg_rd_in),
        .fwd_em_we(fwd_em_we), .fwd_em_rd(fwd_em_rd), .fwd_em_data(fwd_em_data),
        .fwd_mw_we(fwd_mw_we), .fwd_mw_rd(fwd_mw_rd), .fwd_mw_data(fwd_mw_data),
        .ex_stall(ex_stall),
        .MReg_out(MReg_out), .MR_out(MR_out), .MW_out(MW_out), .EnRW_out(EnRW_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out), .reg_rd_out(reg_rd_out)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic        chk_st;
        logic [3:0]  rd;
        logic        chk_rd;
        logic [3:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_fwd(input logic em_we, input logic [3:0] em_rd, input logic [31:0] em_d,
                           input logic mw_we, input logic [3:0] mw_rd, input logic [31:0] mw_d);
        fwd_em_we = em_we; fwd_em_rd = em_rd; fwd_em_data = em_d;
        fwd_mw_we = mw_we; fwd_mw_rd = mw_rd; fwd_mw_data = mw_d;
    endtask

    // ctrl = {MReg, MR, MW, EnRW}
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [3:0] rs, input logic [3:0] rt,
                         input logic [3:0] rd, input logic src, input logic [3:0] ctrl);
        opcode_in = op; rd1_in = a; rd2_in = b; sign_ext_in = imm;
        reg_rs_in = rs; reg_rt_in = rt; reg_rd_in = rd; ALU_src_in = src;
        {MReg_in, MR_in, MW_in, EnRW_in} = ctrl;
    endtask

    task automatic push(input logic [31:0] alu, input logic [31:0] st, input logic chk_st,
                        input logic [3:0] rd, input logic chk_rd, input logic [3:0] ctrl);
        exp_t e;
        e.alu = alu; e.st = st; e.chk_st = chk_st; e.rd = rd; e.chk_rd = chk_rd; e.ctrl = ctrl;
        sb.push_back(e);
    endtask

    task automatic compare_head(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_alu"}, alu_result_out, e.alu);
            chk({tag, "_ctrl"}, 32'(ctrl_o), 32'(e.ctrl));
            if (e.chk_rd) chk({tag, "_rd"}, 32'(reg_rd_out), 32'(e.rd));
            if (e.chk_st) chk({tag, "_st"}, store_data_out, e.st);
        end
    endtask

    // Called right after inputs change at a negedge; ends on the following negedge.
    task automatic step(input string tag);
        #1 chk({tag, "_stall"}, 32'(ex_stall), 32'd0);
        @(posedge clk);
        #1 compare_head(tag);
        @(negedge clk);
    endtask

    // A is supplied through MEM/WB forwarding, which is withdrawn after the capture edge.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
        int   stalls = 0;
        int   bad    = 0;
        logic fin    = 1'b0;
        logic s;
        set_fwd(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, a);
        issue(4'hA, 32'h7, b, 32'd0, 4'd2, 4'd3, rd, 1'b0, 4'b0001);
        push(a * b, 32'd0, 1'b0, rd, 1'b1, 4'b0001);
        for (int i = 0; i < 40 && !fin; i++) begin
            #1 s = ex_stall;
            @(posedge clk);
            #1;
            if (s) begin
                stalls++;
                if (alu_result_out !== 32'd0 || ctrl_o !== 4'd0 || reg_rd_out !== 4'd0) bad++;
            end else begin
                fin = 1'b1;
                compare_head(tag);
            end
            @(negedge clk);
            set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        end
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'd33);
        chk({tag, "_bubbles"}, 32'(bad), 32'd0);
        chk({tag, "_finished"}, 32'(fin), 32'd1);
        if (!fin && sb.size() != 0) sb.delete(0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(4'h0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        chk("rst_alu", alu_result_out, 32'd0);
        chk("rst_ctrl", 32'(ctrl_o), 32'd0);
        chk("rst_rd", 32'(reg_rd_out), 32'd0);
        chk("rst_stall", 32'(ex_stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 5 + 7 -> r3
        issue(4'h0, 32'd5, 32'd7, 32'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'b0001);
        push(32'd12, 32'd7, 1'b0, 4'd3, 1'b1, 4'b0001);
        step("add");

        // SUB with both stages targeting rs=2: EX/MEM wins
        set_fwd(1'b1, 4'd2, 32'h10, 1'b1, 4'd2, 32'h20);
        issue(4'h1, 32'h99, 32'd0, 32'd0, 4'd2, 4'd0, 4'd5, 1'b0, 4'b0001);
        push(32'h10, 32'd0, 1'b0, 4'd5, 1'b1, 4'b0001);
        step("fwd_em");

        // Only MEM/WB matches
        set_fwd(1'b1, 4'd7, 32'h10, 1'b1, 4'd2, 32'h20);
        push(32'h20, 32'd0, 1'b0, 4'd5, 1'b1, 4'b0001);
        step("fwd_mw");

        // Forwarding destinations r0: no forwarding
        set_fwd(1'b1, 4'd0, 32'h10, 1'b1, 4'd0, 32'h20);
        push(32'h99, 32'd0, 1'b0, 4'd5, 1'b1, 4'b0001);
        step("fwd_none");
        set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        // SLT signed: -1 < 1
        issue(4'h7, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd1, 4'd2, 4'd6, 1'b0, 4'b0001);
        push(32'd1, 32'd0, 1'b0, 4'd6, 1'b1, 4'b0001);
        step("slt");

        // SRL 0x80000000 by 31
        issue(4'h6, 32'h8000_0000, 32'd31, 32'd0, 4'd1, 4'd2, 4'd7, 1'b0, 4'b0001);
        push(32'd1, 32'd0, 1'b0, 4'd7, 1'b1, 4'b0001);
        step("srl");

        // SLL by immediate 4
        issue(4'h5, 32'd1, 32'd0, 32'd4, 4'd1, 4'd2, 4'd7, 1'b1, 4'b0001);
        push(32'd16, 32'd0, 1'b0, 4'd7, 1'b1, 4'b0001);
        step("sll");

        // AND / OR / XOR
        issue(4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 4'd1, 4'd2, 4'd8, 1'b0, 4'b0001);
        push(32'h00F0_1200, 32'd0, 1'b0, 4'd8, 1'b1, 4'b0001);
        step("and");
        issue(4'h3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 4'd1, 4'd2, 4'd8, 1'b0, 4'b0001);
        push(32'hFFF0_FF34, 32'd0, 1'b0, 4'd8, 1'b1, 4'b0001);
        step("or");
        issue(4'h4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 4'd1, 4'd2, 4'd8, 1'b0, 4'b0001);
        push(32'hFF00_ED34, 32'd0, 1'b0, 4'd8, 1'b1, 4'b0001);
        step("xor");

        // SW: address 100 + (-4), store data forwarded from EX/MEM for rt=6
        set_fwd(1'b1, 4'd6, 32'h0000_CAFE, 1'b0, 4'd0, 32'd0);
        issue(4'h9, 32'd100, 32'h0000_DEAD, 32'hFFFF_FFFC, 4'd1, 4'd6, 4'd0, 1'b1, 4'b0010);
        push(32'd96, 32'h0000_CAFE, 1'b1, 4'd0, 1'b0, 4'b0010);
        step("sw");
        set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);

        // LW: address 0x200 + 8 -> r9
        issue(4'h8, 32'h200, 32'd0, 32'd8, 4'd1, 4'd2, 4'd9, 1'b1, 4'b1101);
        push(32'h208, 32'd0, 1'b0, 4'd9, 1'b1, 4'b1101);
        step("lw");

        // ADD wraps modulo 2^32
        issue(4'h0, 32'hFFFF_FFFF, 32'd2, 32'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'b0001);
        push(32'd1, 32'd0, 1'b0, 4'd3, 1'b1, 4'b0001);
        step("add_wrap");

        // Opcode C is a NOP even with control bits set
        issue(4'hC, 32'd5, 32'd7, 32'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'b1111);
        push(32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'b0000);
        step("nop_c");

`ifdef EX_MUL_EN
        run_mul("mul1", 32'h0001_0003, 32'h0000_0005, 4'd4);
        run_mul("mul2", 32'hFFFF_FFFF, 32'h0000_0003, 4'd5);

        // Async reset in BUSY cycle 10, then the held MUL restarts from scratch
        set_fwd(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        issue(4'hA, 32'h0001_0003, 32'h0000_0005, 32'd0, 4'd1, 4'd2, 4'd4, 1'b0, 4'b0001);
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(ex_stall), 32'd0);
        chk("midrst_alu", alu_result_out, 32'd0);
        chk("midrst_ctrl", 32'(ctrl_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mul("mul_after_rst", 32'h0001_0003, 32'h0000_0005, 4'd4);
`else
        // Opcode A without the multiplier: NOP, never stalls
        issue(4'hA, 32'h0001_0003, 32'h0000_0005, 32'd0, 4'd1, 4'd2, 4'd4, 1'b0, 4'b0001);
        push(32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'b0000);
        step("mul_off");
        for (int i = 0; i < 5; i++) begin
            push(32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'b0000);
            step("mul_off_hold");
        end
`endif

        // Single-cycle op still correct after the above
        issue(4'h1, 32'd50, 32'd8, 32'd0, 4'd1, 4'd2, 4'd10, 1'b0, 4'b0001);
        push(32'd42, 32'd0, 1'b0, 4'd10, 1'b1, 4'b0001);
        step("sub_tail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC pipeline. Consumes the ID/EX pipeline register outputs and resolves operand forwarding from EX/MEM and MEM/WB.
- Computes the ALU result. Runs an optional iterative 32-cycle multiply that stalls the front end.
- Registers everything into the EX/MEM boundary; this block owns the EX/MEM register.

Parameters:
- DW, 32, datapath width.
- RW, 4, register-address width (16 registers; r0 reads zero).
- MUL_CYC, 32, multiply iterations; must equal DW.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- MReg_in, MR_in, MW_in, ALU_src_in, EnRW_in  in  1 each  control bits from ID/EX
- opcode_in  in  4  opcode from ID/EX
- rd1_in, rd2_in, sign_ext_in  in  DW each  operands and immediate from ID/EX
- reg_rs_in, reg_rt_in, reg_rd_in  in  RW each  register addresses from ID/EX
- fwd_em_we  in  1  EX/MEM write enable (fed back from EnRW_out)
- fwd_em_rd  in  RW  EX/MEM destination
- fwd_em_data  in  DW  EX/MEM result
- fwd_mw_we  in  1  MEM/WB write enable
- fwd_mw_rd  in  RW  MEM/WB destination
- fwd_mw_data  in  DW  MEM/WB writeback data
- ex_stall  out  1  combinational; high = upstream must hold PC, IF/ID and ID/EX
- MReg_out, MR_out, MW_out, EnRW_out  out  1 each  EX/MEM control
- alu_result_out  out  DW  EX/MEM ALU result or address
- store_data_out  out  DW  forwarded rt value for SW
- reg_rd_out  out  RW  EX/MEM destination

Behaviour:
- Reset (async, rst_n=0): all EX/MEM outputs 0; FSM to IDLE; counter 0; ex_stall 0.
- Forwarding, per operand A (rs) and B (rt):
  - EX/MEM wins when fwd_em_we=1, fwd_em_rd==addr, addr!=0.
  - Else MEM/WB under the same rule.
  - Else rd1_in / rd2_in.
- Operand B for ALU = ALU_src_in ? sign_ext_in : forwarded rt.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: shift amount = B[4:0].
  - 7 SLT: signed, result 1 or 0.
  - 8 LW, 9 SW: A+B address.
  - A MUL: low DW bits of the product.
  - B–F NOP: result 0, all control outputs forced 0.
- Arithmetic wraps modulo 2^DW; no overflow flag.
- Single-cycle ops: latency 1. EX/MEM updates on the next clk edge; ex_stall stays 0.
- MUL FSM:
  - IDLE with opcode_in=A: ex_stall=1; latch forwarded A, B; cnt<=0; go BUSY. EX/MEM loads a bubble (all control 0, data 0).
  - BUSY: one shift-add step per cycle; ex_stall=1; EX/MEM loads a bubble each cycle. At cnt==MUL_CYC-1 go DONE.
  - DONE: ex_stall=0; EX/MEM loads the product with ID/EX control bits and reg_rd; go IDLE.
  - Total MUL occupancy: MUL_CYC+2 cycles. ID/EX holds the MUL throughout, so DONE sees the same inputs.
  - Forwarded operands are captured only in the IDLE cycle; later forwarding changes during BUSY are ignored.
- Back-to-back MULs: the second MUL is seen in IDLE after DONE and starts a fresh sequence.
- Reset mid-multiply: FSM returns to IDLE, partial product discarded, ex_stall drops immediately.
- No flush input: a squashed instruction arrives from ID/EX with control bits 0.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: iterative multiplier and FSM as above.
- Undefined: opcode A decodes as NOP (result 0, control 0); no multiplier hardware; ex_stall tied 0.

Decomposition:
- Shared package ex_pkg:
  - opcode localparams OP_ADD..OP_MUL
  - FSM state typedef {IDLE, BUSY, DONE}
  - DW/RW defaults
- One sub-module, ex_mul_seq: start/busy/done handshake, operand latches, counter, shift-add datapath. Instantiated only under EX_MUL_EN.

Test Plan:
- ADD with rd1=5, rd2=7, ALU_src=0, rd=3, EnRW=1 -> next edge: alu_result_out=12, reg_rd_out=3, EnRW_out=1, ex_stall=0.
- Forwarding:
  - EX/MEM rd=2 data=0x10, MEM/WB rd=2 data=0x20, instr SUB rs=2 rt=0 -> result 0x10 (EX/MEM priority).
  - Same stimulus with both fwd rd=0 -> no forwarding, uses rd1_in.
- SLT rs=0xFFFFFFFF, rt=1 -> 1; SRL 0x80000000 by B=31 -> 1; SW with sign_ext=-4, rs=100 -> 96, store_data_out = forwarded rt.
- MUL 0x0001_0003 × 0x0000_0005 (EX_MUL_EN) -> ex_stall high for exactly 33 cycles; bubbles on EX/MEM meanwhile; then result 0x0005_000F with EnRW_out=1. Back-to-back MUL repeats the sequence.
- rst_n low at BUSY cycle 10 -> all outputs 0 asynchronously, ex_stall 0. After release, a pending MUL restarts from cnt 0.
- Build without EX_MUL_EN, opcode A -> result 0, EnRW_out=0, ex_stall never asserted.
